dispatch_decoder: RTL and testbench

Parametrised decode/dispatch stage between ifetch and the out-of-order back end (ROB, RS, LSB, register file). It buffers fetched instructions in an IQ_DEPTH-entry queue, decodes the queue head, resolves operands from the register file, the ROB and CDB_NUM broadcast channels, and issues one registered dispatch packet per cycle when the targeted back-end units have room. A JALR whose rs1 is not yet available is tracked by a wait FSM that snoops all CDB channels and produces a one-cycle redirect.

---
 rtl/dispatch_decoder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_dispatch_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_decoder.sv
// Decode/dispatch stage: buffers fetched instructions, resolves operands from RF/ROB/CDB,
// issues one registered packet per cycle and tracks JALR targets that are still pending.
module dispatch_decoder #(
    parameter int ROB_W    = 4,
    parameter int IQ_DEPTH = 4,
    parameter int CDB_NUM  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rollback,
    input  logic                     inst_valid,
    input  logic [31:0]              inst,
    input  logic [31:0]              inst_pc,
    input  logic                     pred_jump,
    output logic                     inst_ready,
    output logic [4:0]               rs1_index,
    output logic [4:0]               rs2_index,
    input  logic                     rs1_dirty,
    input  logic                     rs2_dirty,
    input  logic [ROB_W-1:0]         rs1_tag,
    input  logic [ROB_W-1:0]         rs2_tag,
    input  logic [31:0]              rs1_value,
    input  logic [31:0]              rs2_value,
    input  logic                     rs1_rob_rdy,
    input  logic                     rs2_rob_rdy,
    input  logic [31:0]              rs1_rob_value,
    input  logic [31:0]              rs2_rob_value,
    input  logic [ROB_W-1:0]         next_rob_tag,
    input  logic                     rob_full,
    input  logic                     rs_full,
    input  logic                     lsb_full,
    input  logic [CDB_NUM-1:0]       cdb_valid,
    input  logic [CDB_NUM*ROB_W-1:0] cdb_tag,
    input  logic [CDB_NUM*32-1:0]    cdb_value,
    output logic                     issue_valid,
    output logic [31:0]              issue_pc,
    output logic [31:0]              issue_imm,
    output logic [6:0]               issue_opcode,
    output logic [2:0]               issue_funct3,
    output logic                     issue_f7b,
    output logic [4:0]               issue_rd,
    output logic [ROB_W-1:0]         issue_tag,
    output logic                     issue_q1_busy,
    output logic                     issue_q2_busy,
    output logic [ROB_W-1:0]         issue_q1,
    output logic [ROB_W-1:0]         issue_q2,
    output logic [31:0]              issue_v1,
    output logic [31:0]              issue_v2,
    output logic                     issue_to_rs,
    output logic                     issue_to_lsb,
    output logic                     issue_is_store,
    output logic                     issue_wr_rf,
    output logic                     issue_pred_jump,
    output logic [1:0]               issue_rob_type,
    output logic                     issue_rob_ready,
    output logic [31:0]              issue_rob_value,
    output logic                     jalr_stall,
    output logic                     jalr_redirect_valid,
    output logic [31:0]              jalr_redirect_pc
);
    localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(IQ_DEPTH);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;

    typedef enum logic {IDLE, WAIT_JALR} state_t;

    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic             f7b;
        logic [4:0]       rd;
        logic [ROB_W-1:0] tag;
        logic             q1_busy;
        logic [ROB_W-1:0] q1;
        logic [31:0]      v1;
        logic             q2_busy;
        logic [ROB_W-1:0] q2;
        logic [31:0]      v2;
        logic             to_rs;
        logic             to_lsb;
        logic             is_store;
        logic             wr_rf;
        logic             pred_jump;
        logic [1:0]       rob_type;
        logic             rob_ready;
        logic [31:0]      rob_value;
    } issue_t;

    function automatic logic [32:0] cdb_lookup(input logic [ROB_W-1:0] tag,
                                               input logic [CDB_NUM-1:0] cv,
                                               input logic [CDB_NUM*ROB_W-1:0] ct,
                                               input logic [CDB_NUM*32-1:0] cval);
        logic [32:0] r;
        r = '0;
        // Descending scan so the lowest-index channel is the last writer and wins.
        for (int i = CDB_NUM - 1; i >= 0; i--)
            if (cv[i] && ct[i*ROB_W +: ROB_W] == tag) r = {1'b1, cval[i*32 +: 32]};
        return r;
    endfunction

    function automatic logic [ROB_W+32:0] resolve(input logic use_reg, input logic [4:0] idx,
                                                  input logic dirty, input logic [ROB_W-1:0] tag,
                                                  input logic [31:0] rf_v, input logic rob_rdy,
                                                  input logic [31:0] rob_v, input logic [32:0] hit);
        if (!use_reg || idx == 5'd0) return '0;
        else if (!dirty)             return {1'b0, {ROB_W{1'b0}}, rf_v};
        else if (rob_rdy)            return {1'b0, {ROB_W{1'b0}}, rob_v};
        else if (hit[32])            return {1'b0, {ROB_W{1'b0}}, hit[31:0]};
        else                         return {1'b1, tag, 32'd0};
    endfunction

    logic [31:0]        iq_inst [IQ_DEPTH];
    logic [31:0]        iq_pc   [IQ_DEPTH];
    logic               iq_pred [IQ_DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [PTR_W:0]     count;
    state_t             state;
    logic [ROB_W-1:0]   wait_tag;
    logic [31:0]        wait_imm;
    issue_t             dec_p0, issue_p1;
    logic [31:0]        h_inst;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic               known, is_jalr, use1, use2, target_ok, head_ok, fire, deq, enq;
    logic [ROB_W+32:0]  op1_r, op2_r;
    logic [32:0]        wait_hit;

    assign h_inst     = iq_inst[head];
    assign rs1_index  = h_inst[19:15];
    assign rs2_index  = h_inst[24:20];
    assign inst_ready = (count != CNT_FULL);
    assign imm_i = {{20{h_inst[31]}}, h_inst[31:20]};
    assign imm_s = {{20{h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
    assign imm_b = {{19{h_inst[31]}}, h_inst[31], h_inst[7], h_inst[30:25], h_inst[11:8], 1'b0};
    assign imm_u = {h_inst[31:12], 12'd0};
    assign imm_j = {{11{h_inst[31]}}, h_inst[31], h_inst[19:12], h_inst[20], h_inst[30:21], 1'b0};

    // Stage p0: decode and operand resolution of the queue head.
    always_comb begin
        dec_p0           = '0;
        known            = 1'b1;
        is_jalr          = 1'b0;
        use1             = 1'b0;
        use2             = 1'b0;
        dec_p0.valid     = 1'b1;
        dec_p0.pc        = iq_pc[head];
        dec_p0.opcode    = h_inst[6:0];
        dec_p0.funct3    = h_inst[14:12];
        dec_p0.f7b       = h_inst[30];
        dec_p0.rd        = h_inst[11:7];
        dec_p0.tag       = next_rob_tag;
        dec_p0.pred_jump = iq_pred[head];
        dec_p0.wr_rf     = 1'b1;
        case (h_inst[6:0])
            OP_LUI:   begin dec_p0.imm = imm_u; dec_p0.rob_ready = 1'b1; dec_p0.rob_value = imm_u; end
            OP_AUIPC: begin dec_p0.imm = imm_u; dec_p0.to_rs = 1'b1; end
            OP_JAL:   begin dec_p0.imm = imm_j; dec_p0.to_rs = 1'b1; end
            OP_JALR:  begin
                is_jalr = 1'b1; use1 = 1'b1; dec_p0.imm = imm_i;
                dec_p0.rob_ready = 1'b1; dec_p0.rob_value = dec_p0.pc + 32'd4;
            end
            OP_BR:    begin
                use1 = 1'b1; use2 = 1'b1; dec_p0.imm = imm_b; dec_p0.to_rs = 1'b1;
                dec_p0.rd = 5'd0; dec_p0.wr_rf = 1'b0; dec_p0.rob_type = 2'b10;
            end
            OP_LD:    begin use1 = 1'b1; dec_p0.imm = imm_i; dec_p0.to_lsb = 1'b1; end
            OP_ST:    begin
                use1 = 1'b1; use2 = 1'b1; dec_p0.imm = imm_s; dec_p0.to_lsb = 1'b1;
                dec_p0.is_store = 1'b1; dec_p0.rd = 5'd0; dec_p0.wr_rf = 1'b0;
                dec_p0.rob_type = 2'b01; dec_p0.rob_ready = 1'b1;
            end
            OP_IMM:   begin use1 = 1'b1; dec_p0.imm = imm_i; dec_p0.to_rs = 1'b1; end
            OP_OP:    begin use1 = 1'b1; use2 = 1'b1; dec_p0.to_rs = 1'b1; end
            default:  known = 1'b0;
        endcase
        op1_r = resolve(use1, rs1_index, rs1_dirty, rs1_tag, rs1_value, rs1_rob_rdy, rs1_rob_value,
                        cdb_lookup(rs1_tag, cdb_valid, cdb_tag, cdb_value));
        op2_r = resolve(use2, rs2_index, rs2_dirty, rs2_tag, rs2_value, rs2_rob_rdy, rs2_rob_value,
                        cdb_lookup(rs2_tag, cdb_valid, cdb_tag, cdb_value));
        {dec_p0.q1_busy, dec_p0.q1, dec_p0.v1} = op1_r;
        {dec_p0.q2_busy, dec_p0.q2, dec_p0.v2} = op2_r;
    end

    assign target_ok = dec_p0.to_lsb ? !lsb_full : (dec_p0.to_rs ? !rs_full : 1'b1);
    assign head_ok   = (count != '0) && (state == IDLE);
    assign fire      = head_ok && known && !rob_full && target_ok;
    assign deq       = fire || (head_ok && !known);
    assign enq       = rdy && !rollback && inst_valid && inst_ready;
    assign wait_hit  = cdb_lookup(wait_tag, cdb_valid, cdb_tag, cdb_value);

    always_ff @(posedge clk) begin
        if (enq) begin
            iq_inst[tail] <= inst;
            iq_pc[tail]   <= inst_pc;
            iq_pred[tail] <= pred_jump;
        end
    end

    // Stage p1: registered dispatch packet, queue pointers and JALR wait FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0; tail <= '0; count <= '0; state <= IDLE;
            issue_p1 <= '0; jalr_stall <= 1'b0; jalr_redirect_valid <= 1'b0;
            jalr_redirect_pc <= '0; wait_tag <= '0; wait_imm <= '0;
        end else if (!rdy) begin
            issue_p1.valid      <= 1'b0;
            jalr_redirect_valid <= 1'b0;
        end else if (rollback) begin
            head <= '0; tail <= '0; count <= '0; state <= IDLE;
            issue_p1 <= '0; jalr_stall <= 1'b0; jalr_redirect_valid <= 1'b0;
        end else begin
            issue_p1.valid      <= 1'b0;
            jalr_redirect_valid <= 1'b0;
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
            if (fire) begin
                issue_p1 <= dec_p0;
                if (is_jalr && !dec_p0.q1_busy) begin
                    jalr_redirect_valid <= 1'b1;
                    jalr_redirect_pc    <= (dec_p0.v1 + dec_p0.imm) & 32'hFFFF_FFFE;
                end else if (is_jalr) begin
                    state      <= WAIT_JALR;
                    wait_tag   <= dec_p0.q1;
                    wait_imm   <= dec_p0.imm;
                    jalr_stall <= 1'b1;
                end
            end
            if (state == WAIT_JALR && wait_hit[32]) begin
                state               <= IDLE;
                jalr_stall          <= 1'b0;
                jalr_redirect_valid <= 1'b1;
                jalr_redirect_pc    <= (wait_hit[31:0] + wait_imm) & 32'hFFFF_FFFE;
            end
        end
    end

    assign issue_valid     = issue_p1.valid;
    assign issue_pc        = issue_p1.pc;
    assign issue_imm       = issue_p1.imm;
    assign issue_opcode    = issue_p1.opcode;
    assign issue_funct3    = issue_p1.funct3;
    assign issue_f7b       = issue_p1.f7b;
    assign issue_rd        = issue_p1.rd;
    assign issue_tag       = issue_p1.tag;
    assign issue_q1_busy   = issue_p1.q1_busy;
    assign issue_q1        = issue_p1.q1;
    assign issue_v1        = issue_p1.v1;
    assign issue_q2_busy   = issue_p1.q2_busy;
    assign issue_q2        = issue_p1.q2;
    assign issue_v2        = issue_p1.v2;
    assign issue_to_rs     = issue_p1.to_rs;
    assign issue_to_lsb    = issue_p1.to_lsb;
    assign issue_is_store  = issue_p1.is_store;
    assign issue_wr_rf     = issue_p1.wr_rf;
    assign issue_pred_jump = issue_p1.pred_jump;
    assign issue_rob_type  = issue_p1.rob_type;
    assign issue_rob_ready = issue_p1.rob_ready;
    assign issue_rob_value = issue_p1.rob_value;
endmodule

// File: tb/tb_dispatch_decoder.sv
// Scoreboard bench for dispatch_decoder: directed instruction vectors with hand-computed packets.
module tb_dispatch_decoder;
    localparam int ROB_W = 4, IQ_DEPTH = 4, CDB_NUM = 2;

    logic clk, rst, rdy, rollback, inst_valid, pred_jump, inst_ready;
    logic [31:0] inst, inst_pc;
    logic [4:0] rs1_index, rs2_index;
    logic rs1_dirty, rs2_dirty, rs1_rob_rdy, rs2_rob_rdy;
    logic [ROB_W-1:0] rs1_tag, rs2_tag, next_rob_tag;
    logic [31:0] rs1_value, rs2_value, rs1_rob_value, rs2_rob_value;
    logic rob_full, rs_full, lsb_full;
    logic [CDB_NUM-1:0] cdb_valid;
    logic [CDB_NUM*ROB_W-1:0] cdb_tag;
    logic [CDB_NUM*32-1:0] cdb_value;
    logic issue_valid, issue_f7b, issue_q1_busy, issue_q2_busy, issue_to_rs, issue_to_lsb;
    logic issue_is_store, issue_wr_rf, issue_pred_jump, issue_rob_ready;
    logic [31:0] issue_pc, issue_imm, issue_v1, issue_v2, issue_rob_value, jalr_redirect_pc;
    logic [6:0] issue_opcode;
    logic [2:0] issue_funct3;
    logic [4:0] issue_rd;
    logic [ROB_W-1:0] issue_tag, issue_q1, issue_q2;
    logic [1:0] issue_rob_type;
    logic jalr_stall, jalr_redirect_valid;

    dispatch_decoder #(.ROB_W(ROB_W), .IQ_DEPTH(IQ_DEPTH), .CDB_NUM(CDB_NUM)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pred_jump(pred_jump),
        .inst_ready(inst_ready), .rs1_index(rs1_index), .rs2_index(rs2_index),
        .rs1_dirty(rs1_dirty), .rs2_dirty(rs2_dirty), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_value(rs1_value), .rs2_value(rs2_value), .rs1_rob_rdy(rs1_rob_rdy),
        .rs2_rob_rdy(rs2_rob_rdy), .rs1_rob_value(rs1_rob_value), .rs2_rob_value(rs2_rob_value),
        .next_rob_tag(next_rob_tag), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .issue_opcode(issue_opcode), .issue_funct3(issue_funct3), .issue_f7b(issue_f7b),
        .issue_rd(issue_rd), .issue_tag(issue_tag), .issue_q1_busy(issue_q1_busy),
        .issue_q2_busy(issue_q2_busy), .issue_q1(issue_q1), .issue_q2(issue_q2),
        .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_to_rs(issue_to_rs),
        .issue_to_lsb(issue_to_lsb), .issue_is_store(issue_is_store), .issue_wr_rf(issue_wr_rf),
        .issue_pred_jump(issue_pred_jump), .issue_rob_type(issue_rob_type),
        .issue_rob_ready(issue_rob_ready), .issue_rob_value(issue_rob_value),
        .jalr_stall(jalr_stall), .jalr_redirect_valid(jalr_redirect_valid),
        .jalr_redirect_pc(jalr_redirect_pc)
    );

    typedef struct {
        logic [31:0] pc, imm, v1, v2, rv;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [3:0]  tag, q1, q2;
        logic        chk_imm, chk1, b1, chk2, b2, to_rs, to_lsb, st, wr, rr, chk_rv;
        logic [1:0]  rt;
    } pkt_t;

    pkt_t exp_q[$];
    logic [31:0] redir_q[$];
    pkt_t mp, p;
    int checks = 0, errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a packet or redirect.
    always @(negedge clk) begin
        if (!rst && issue_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_issue actual_pc=%h required=no_issue", issue_pc);
            end else begin
                mp = exp_q.pop_front();
                chk("pc", issue_pc, mp.pc);
                chk("opcode", 32'(issue_opcode), 32'(mp.op));
                chk("rd", 32'(issue_rd), 32'(mp.rd));
                chk("tag", 32'(issue_tag), 32'(mp.tag));
                if (mp.chk_imm) chk("imm", issue_imm, mp.imm);
                if (mp.chk1) begin
                    chk("q1_busy", 32'(issue_q1_busy), 32'(mp.b1));
                    if (mp.b1) chk("q1", 32'(issue_q1), 32'(mp.q1));
                    else chk("v1", issue_v1, mp.v1);
                end
                if (mp.chk2) begin
                    chk("q2_busy", 32'(issue_q2_busy), 32'(mp.b2));
                    if (mp.b2) chk("q2", 32'(issue_q2), 32'(mp.q2));
                    else chk("v2", issue_v2, mp.v2);
                end
                chk("route", {28'd0, issue_to_rs, issue_to_lsb, issue_is_store, issue_wr_rf},
                    {28'd0, mp.to_rs, mp.to_lsb, mp.st, mp.wr});
                chk("rob_type", 32'(issue_rob_type), 32'(mp.rt));
                chk("rob_ready", 32'(issue_rob_ready), 32'(mp.rr));
                if (mp.chk_rv) chk("rob_value", issue_rob_value, mp.rv);
            end
        end
        if (!rst && jalr_redirect_valid) begin
            if (redir_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_redirect actual_pc=%h required=no_redirect", jalr_redirect_pc);
            end else chk("redirect_pc", jalr_redirect_pc, redir_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic enq(input logic [31:0] w, input logic [31:0] pc);
        inst_valid = 1'b1; inst = w; inst_pc = pc;
        tick();
        inst_valid = 1'b0;
    endtask

    function automatic pkt_t base(input logic [31:0] pc, input logic [6:0] op,
                                  input logic [4:0] rd, input logic [3:0] tag);
        pkt_t r;
        r = '{default: '0};
        r.pc = pc; r.op = op; r.rd = rd; r.tag = tag; r.wr = 1'b1; r.chk_imm = 1'b1; r.chk1 = 1'b1;
        return r;
    endfunction

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || redir_q.size() != 0) && n < 20) begin tick(); n++; end
        if (exp_q.size() != 0 || redir_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual_pending=%0d required=0", exp_q.size() + redir_q.size());
        end
    endtask

    task automatic clear_ops();
        rs1_dirty = 0; rs2_dirty = 0; rs1_rob_rdy = 0; rs2_rob_rdy = 0;
        rs1_tag = 0; rs2_tag = 0; rs1_value = 0; rs2_value = 0;
        rs1_rob_value = 0; rs2_rob_value = 0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    endtask

    initial begin
        rst = 1; rdy = 1; rollback = 0; inst_valid = 0; inst = 0; inst_pc = 0; pred_jump = 0;
        next_rob_tag = 0; rob_full = 0; rs_full = 0; lsb_full = 0;
        clear_ops();
        tick(); tick();
        rst = 0;
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_stall", 32'(jalr_stall), 32'd0);
        chk("rst_redirect", 32'(jalr_redirect_valid), 32'd0);
        chk("rst_inst_ready", 32'(inst_ready), 32'd1);
        chk("rst_issue_pc", issue_pc, 32'd0);

        // addi x1,x0,5
        next_rob_tag = 4'd5;
        p = base(32'h0, 7'h13, 5'd1, 4'd5); p.imm = 32'd5; p.to_rs = 1;
        exp_q.push_back(p); enq(32'h00500093, 32'h0); drain();

        // addi x2,x6,16: operand from CDB channel 1 in the same cycle
        rs1_dirty = 1; rs1_tag = 4'd3; cdb_valid = 2'b10;
        cdb_tag = {4'd3, 4'd0}; cdb_value = {32'h1234, 32'h0};
        p = base(32'h4, 7'h13, 5'd2, 4'd5); p.imm = 32'h10; p.to_rs = 1; p.v1 = 32'h1234;
        exp_q.push_back(p); enq(32'h01030113, 32'h4); drain();
        cdb_valid = 2'b00;
        p = base(32'h8, 7'h13, 5'd2, 4'd5); p.imm = 32'h10; p.to_rs = 1; p.b1 = 1; p.q1 = 4'd3;
        exp_q.push_back(p); enq(32'h01030113, 32'h8); drain();
        cdb_valid = 2'b11; cdb_tag = {4'd3, 4'd3}; cdb_value = {32'h2222, 32'h1111};
        p = base(32'hC, 7'h13, 5'd2, 4'd5); p.imm = 32'h10; p.to_rs = 1; p.v1 = 32'h1111;
        exp_q.push_back(p); enq(32'h01030113, 32'hC); drain();
        rs1_rob_rdy = 1; rs1_rob_value = 32'hAAAA;
        p = base(32'h10, 7'h13, 5'd2, 4'd5); p.imm = 32'h10; p.to_rs = 1; p.v1 = 32'hAAAA;
        exp_q.push_back(p); enq(32'h01030113, 32'h10); drain();
        // add x3,x6,x0: x0 resolves to zero even when marked dirty
        clear_ops(); rs1_value = 32'h55; rs2_dirty = 1; rs2_tag = 4'd7;
        p = base(32'h14, 7'h33, 5'd3, 4'd5); p.chk_imm = 0; p.to_rs = 1; p.v1 = 32'h55; p.chk2 = 1;
        exp_q.push_back(p); enq(32'h000301B3, 32'h14); drain();

        // jalr x1,0(x5) with x5 pending on tag 2
        clear_ops(); next_rob_tag = 4'd6; rs1_dirty = 1; rs1_tag = 4'd2;
        p = base(32'h100, 7'h67, 5'd1, 4'd6); p.b1 = 1; p.q1 = 4'd2;
        p.rr = 1; p.chk_rv = 1; p.rv = 32'h104;
        exp_q.push_back(p); enq(32'h000280E7, 32'h100); tick();
        chk("jalr_stall_set", 32'(jalr_stall), 32'd1);
        tick(); tick();
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_value = {32'h0, 32'h201};
        redir_q.push_back(32'h200); tick();
        cdb_valid = 2'b00;
        chk("jalr_redirect_pulse", 32'(jalr_redirect_valid), 32'd1);
        chk("jalr_stall_clear", 32'(jalr_stall), 32'd0);
        tick();
        chk("jalr_redirect_once", 32'(jalr_redirect_valid), 32'd0);
        drain();
        // jalr x1,4(x5) with x5 resolved: redirect in the dispatch edge
        clear_ops(); rs1_value = 32'h301;
        p = base(32'h200, 7'h67, 5'd1, 4'd6); p.imm = 32'd4; p.v1 = 32'h301;
        p.rr = 1; p.chk_rv = 1; p.rv = 32'h204;
        exp_q.push_back(p); redir_q.push_back(32'h304); enq(32'h004280E7, 32'h200); tick();
        chk("jalr_resolved_no_stall", 32'(jalr_stall), 32'd0);
        drain();

        // Four loads against a full LSB
        clear_ops(); next_rob_tag = 4'd7; lsb_full = 1;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) chk("inst_ready_3", 32'(inst_ready), 32'd1);
            enq(32'h00002003 | (32'(k) << 7), 32'h300 + 32'(4 * k));
        end
        chk("inst_ready_full", 32'(inst_ready), 32'd0);
        tick(); tick(); tick();
        for (int k = 1; k <= 4; k++) begin
            p = base(32'h300 + 32'(4 * k), 7'h03, 5'(k), 4'd7); p.to_lsb = 1;
            exp_q.push_back(p);
        end
        lsb_full = 0;
        for (int k = 0; k < 4; k++) begin
            tick(); chk("load_burst", 32'(issue_valid), 32'd1);
        end
        tick(); chk("load_burst_end", 32'(issue_valid), 32'd0);
        drain();

        // Rollback while waiting on a JALR with three queued entries
        next_rob_tag = 4'd8; rs1_dirty = 1; rs1_tag = 4'd2;
        p = base(32'h400, 7'h67, 5'd1, 4'd8); p.b1 = 1; p.q1 = 4'd2;
        p.rr = 1; p.chk_rv = 1; p.rv = 32'h404;
        exp_q.push_back(p); enq(32'h000280E7, 32'h400); tick();
        for (int k = 0; k < 3; k++) enq(32'h00500093, 32'h404 + 32'(4 * k));
        chk("wait_stall", 32'(jalr_stall), 32'd1);
        rollback = 1; tick(); rollback = 0;
        chk("rollback_stall", 32'(jalr_stall), 32'd0);
        chk("rollback_issue", 32'(issue_valid), 32'd0);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_value = {32'h0, 32'h500}; tick();
        cdb_valid = 2'b00;
        chk("rollback_no_redirect", 32'(jalr_redirect_valid), 32'd0);
        tick(); tick();
        clear_ops();
        p = base(32'h480, 7'h13, 5'd1, 4'd8); p.imm = 32'd5; p.to_rs = 1;
        exp_q.push_back(p); enq(32'h00500093, 32'h480); drain();

        // sw x2,8(x1) held by a full ROB
        next_rob_tag = 4'd9; rob_full = 1; rs1_value = 32'h40; rs2_value = 32'h99;
        enq(32'h0020A423, 32'h500); tick(); tick(); tick();
        p = base(32'h500, 7'h23, 5'd0, 4'd9); p.imm = 32'd8; p.v1 = 32'h40; p.chk2 = 1;
        p.v2 = 32'h99; p.to_lsb = 1; p.st = 1; p.wr = 0; p.rt = 2'b01; p.rr = 1;
        exp_q.push_back(p); rob_full = 0; drain();

        // LUI ignores a full RS; addi -1 waits for it
        clear_ops(); next_rob_tag = 4'd10; rs_full = 1;
        p = base(32'h600, 7'h37, 5'd4, 4'd10); p.imm = 32'h12345000; p.chk1 = 0;
        p.rr = 1; p.chk_rv = 1; p.rv = 32'h12345000;
        exp_q.push_back(p); enq(32'h12345237, 32'h600); drain();
        enq(32'hFFF00093, 32'h604); tick(); tick(); tick();
        p = base(32'h604, 7'h13, 5'd1, 4'd10); p.imm = 32'hFFFFFFFF; p.to_rs = 1;
        exp_q.push_back(p); rs_full = 0; drain();

        // Unknown opcode is dropped; beq x6,x7,+16 with x7 pending
        enq(32'hFFFFFFFF, 32'h608);
        p = base(32'h60C, 7'h13, 5'd1, 4'd10); p.imm = 32'd5; p.to_rs = 1;
        exp_q.push_back(p); enq(32'h00500093, 32'h60C); drain();
        rs1_value = 32'h66; rs2_dirty = 1; rs2_tag = 4'd9;
        p = base(32'h610, 7'h63, 5'd0, 4'd10); p.imm = 32'd16; p.v1 = 32'h66; p.chk2 = 1;
        p.b2 = 1; p.q2 = 4'd9; p.to_rs = 1; p.wr = 0; p.rt = 2'b10;
        exp_q.push_back(p); enq(32'h00730863, 32'h610); drain();

        tick(); tick();
        chk("scoreboard_empty", 32'(exp_q.size() + redir_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
